// File: rtl/satcom_pkg.sv
// satcom_pkg: link-buffer constants and drain FSM encoding shared by the satcom buffers
package satcom_pkg;
    localparam int TX_DEPTH     = 1280;
    localparam int WRN_PULSE    = 4;
    localparam int BUSY_TIMEOUT = 16;
    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_EMPTY} drain_state_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO with registered-read RAM, occupancy flags and sticky overflow
module tx_fifo #(
    parameter int DEPTH  = 1280,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        wdata,
    input  logic              pop,
    output logic [7:0]        rdata,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH-1);
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_en, rd_en;
    assign full  = count == FULL_CNT;
    assign empty = count == '0;
    assign rd_en = pop && !empty;
    // a pop in the same cycle frees the slot, so a push while full still lands
    assign wr_en = push && (!full || rd_en);
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
        if (rd_en) rdata <= mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            count <= count + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, rd_en};
            if (push && !wr_en) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/tx_buffer_control.sv
// tx_buffer_control: assembles link bits LSB-first into bytes, buffers them, drains to txmit
module tx_buffer_control #(
    parameter int TX_DEPTH     = satcom_pkg::TX_DEPTH,
    parameter int ADDR_W       = 11,
    parameter int WRN_PULSE    = satcom_pkg::WRN_PULSE,
    parameter int BUSY_TIMEOUT = satcom_pkg::BUSY_TIMEOUT
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_sync,
    input  logic              tbre,
    output logic [7:0]        tdin,
    output logic              wrn,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              tx_overflow,
    output logic [ADDR_W:0]   tx_count
);
    import satcom_pkg::*;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT > WRN_PULSE ? BUSY_TIMEOUT : WRN_PULSE) + 1;
    drain_state_t     state, state_n;
    logic [2:0]       bit_cnt;
    logic [7:0]       sr, rdata;
    logic [TMR_W-1:0] tmr;
    logic             push, pop;
    assign push = bit_valid && !frame_sync && bit_cnt == 3'd7;
    assign pop  = state == IDLE && tbre && !tx_empty;
    tx_fifo #(.DEPTH(TX_DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk(clk_100M), .rst(rst), .push(push), .wdata({bit_in, sr[7:1]}), .pop(pop),
        .rdata(rdata), .full(tx_full), .empty(tx_empty), .overflow(tx_overflow), .count(tx_count)
    );
    // frame_sync drops the partial byte; a coincident bit starts the new one
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            bit_cnt <= '0;
            sr      <= '0;
        end else if (frame_sync) begin
            bit_cnt <= bit_valid ? 3'd1 : 3'd0;
            sr      <= bit_valid ? {bit_in, 7'b0} : 8'h00;
        end else if (bit_valid) begin
            bit_cnt <= bit_cnt + 1'b1;
            sr      <= {bit_in, sr[7:1]};
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (pop) state_n = LOAD;
            LOAD:       state_n = STROBE;
            STROBE:     if (tmr == TMR_W'(WRN_PULSE-1)) state_n = WAIT_BUSY;
            WAIT_BUSY:  state_n = !tbre ? WAIT_EMPTY : tmr == TMR_W'(BUSY_TIMEOUT-1) ? IDLE : WAIT_BUSY;
            WAIT_EMPTY: if (tbre) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end
    // tmr restarts on every state change, timing both the strobe and the busy wait
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            wrn   <= 1'b1;
            tdin  <= 8'h00;
        end else begin
            state <= state_n;
            tmr   <= state_n != state ? '0 : tmr + 1'b1;
            wrn   <= state_n != STROBE;
            if (state == LOAD) tdin <= rdata;
        end
    end
endmodule

// File: tb/tb_tx_buffer_control.sv
// tb_tx_buffer_control: scoreboard bench with a txmit model for tx_buffer_control
module tb_tx_buffer_control;
    logic        clk_100M = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, frame_sync = 1'b0, tbre;
    logic [7:0]  tdin, held;
    logic        wrn, tx_full, tx_empty, tx_overflow;
    logic [11:0] tx_count;
    logic        mon_prev = 1'b1, m_prev = 1'b1, cut = 1'b0;
    logic [7:0]  exp_q[$];
    int npass = 0, ntot = 0, cyc = 0, writes = 0, last_gap = 0, rise_cyc = 0, low_cnt = 0, mode = 1;

    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc <= cyc + 1;

    tx_buffer_control dut (
        .clk_100M(clk_100M), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_sync(frame_sync),
        .tbre(tbre), .tdin(tdin), .wrn(wrn), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_overflow(tx_overflow), .tx_count(tx_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    endtask

    task automatic send_bit(input logic b, input logic fs);
        @(negedge clk_100M);
        bit_in = b; bit_valid = 1'b1; frame_sync = fs;
        @(negedge clk_100M);
        bit_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    endtask

    // txmit model: mode 0 busy forever, 1 normal handshake, 2 tbre never falls
    initial begin
        tbre = 1'b1;
        forever begin
            @(negedge clk_100M);
            if (mode == 0) tbre = 1'b0;
            else if (mode == 2) tbre = 1'b1;
            else begin
                if (m_prev == 1'b0 && wrn == 1'b1 && !rst) begin
                    tbre = 1'b0;
                    repeat (3) @(negedge clk_100M);
                end
                tbre = 1'b1;
            end
            m_prev = wrn;
        end
    end

    // monitor: every falling wrn pops the scoreboard; tdin must hold and pulse width is checked
    always @(negedge clk_100M) begin
        if (!wrn && mon_prev) begin
            last_gap = cyc - rise_cyc;
            low_cnt = 1;
            held = tdin;
            writes++;
            if (exp_q.size() == 0) chk("unexpected_write", int'(tdin), -1);
            else chk("tdin_order", int'(tdin), int'(exp_q.pop_front()));
        end else if (!wrn) begin
            low_cnt++;
            chk("tdin_hold", int'(tdin), int'(held));
        end else if (wrn && !mon_prev) begin
            rise_cyc = cyc;
            if (!cut) chk("wrn_width", low_cnt, 4);
        end
        mon_prev = wrn;
    end

    initial begin
        int k;
        repeat (2) @(negedge clk_100M);
        rst = 1'b0;
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk_100M);
        chk("rst_tdin", int'(tdin), 0);
        chk("rst_wrn", int'(wrn), 1);
        chk("rst_empty", int'(tx_empty), 1);
        chk("rst_full", int'(tx_full), 0);
        chk("rst_ovf", int'(tx_overflow), 0);
        chk("rst_count", int'(tx_count), 0);
        rst = 1'b0;

        // single byte 0xA5 with exact handshake timing
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        chk("a5_count_e", int'(tx_count), 1);
        @(negedge clk_100M);
        chk("a5_wrn_e1", int'(wrn), 1);
        @(negedge clk_100M);
        chk("a5_wrn_e2", int'(wrn), 0);
        chk("a5_tdin_e2", int'(tdin), 'hA5);
        repeat (20) @(negedge clk_100M);
        chk("a5_empty", int'(tx_empty), 1);
        chk("a5_writes", writes, 1);

        // realignment: partial byte discarded by frame_sync
        send_bit(1, 0); send_bit(1, 0); send_bit(1, 0);
        @(negedge clk_100M); frame_sync = 1'b1;
        @(negedge clk_100M); frame_sync = 1'b0;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        repeat (25) @(negedge clk_100M);
        chk("realign_writes", writes, 2);

        // frame_sync coincident with a bit: that bit is bit 0
        send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        exp_q.push_back(8'h81);
        send_bit(1, 1);
        for (int i = 1; i < 8; i++) send_bit(i == 7, 0);
        repeat (25) @(negedge clk_100M);
        chk("fs_same_writes", writes, 3);
        chk("fs_same_empty", int'(tx_empty), 1);

        // fill to full, then one more byte overflows
        mode = 0;
        repeat (5) @(negedge clk_100M);
        for (int i = 0; i < 1281; i++) begin
            if (i < 1280) exp_q.push_back(8'(i));
            send_byte(8'(i));
            if (i == 1278) begin
                chk("fill_count_1279", int'(tx_count), 1279);
                chk("fill_full_1279", int'(tx_full), 0);
            end
            if (i == 1279) begin
                chk("fill_count_1280", int'(tx_count), 1280);
                chk("fill_full_1280", int'(tx_full), 1);
                chk("fill_ovf_1280", int'(tx_overflow), 0);
            end
            if (i == 1280) begin
                chk("ovf_set", int'(tx_overflow), 1);
                chk("ovf_count", int'(tx_count), 1280);
            end
        end
        mode = 1;
        for (k = 0; k < 20000; k++) begin
            @(negedge clk_100M);
            if (exp_q.size() == 0 && tx_empty && wrn && tbre) break;
        end
        chk("drain_in_time", int'(k < 20000), 1);
        chk("drain_writes", writes, 1283);
        chk("ovf_sticky", int'(tx_overflow), 1);
        chk("drain_empty", int'(tx_empty), 1);

        // busy timeout: tbre never falls, second byte still goes out
        @(negedge clk_100M); rst = 1'b1;
        repeat (2) @(negedge clk_100M); rst = 1'b0;
        chk("ovf_cleared", int'(tx_overflow), 0);
        mode = 2;
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
        send_byte(8'h5A); send_byte(8'hC3);
        for (k = 0; k < 200; k++) begin
            @(negedge clk_100M);
            if (writes == 1285) break;
        end
        chk("timeout_writes", writes, 1285);
        chk("timeout_gap", last_gap, 18);
        repeat (30) @(negedge clk_100M);

        // reset during STROBE with a second byte still queued
        mode = 0;
        repeat (5) @(negedge clk_100M);
        exp_q.push_back(8'h77);
        send_byte(8'h77); send_byte(8'h11);
        mode = 1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk_100M);
            if (!wrn) break;
        end
        chk("strobe_seen", int'(wrn), 0);
        cut = 1'b1; rst = 1'b1;
        @(negedge clk_100M);
        chk("rst_strobe_wrn", int'(wrn), 1);
        chk("rst_strobe_empty", int'(tx_empty), 1);
        chk("rst_strobe_count", int'(tx_count), 0);
        @(negedge clk_100M); rst = 1'b0;
        repeat (40) @(negedge clk_100M);
        chk("rst_strobe_no_more", writes, 1286);
        chk("rst_strobe_wrn_idle", int'(wrn), 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        cut = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
